// File: rtl/fwft_arb_pkg.sv
// Shared types and helpers for the FWFT round-robin drain arbiter.
package fwft_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Next channel index with explicit wrap, valid for any channel count.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational priority picker: first set request searching upward from start, with wrap.
module rr_prio_pick
  import fwft_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW-1:0] k;
    found = 1'b0;
    idx   = '0;
    k     = start;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = k;
      end
      k = IW'(next_idx(32'(k), N));
    end
  end

endmodule

// File: rtl/fwft_rr_drain_arb.sv
// Burst-limited round-robin drain of NUM_CH FWFT FIFOs into one valid/ready stream.
// Optional per-channel word counters are built when FWFT_RR_ARB_STATS_EN is defined.
module fwft_rr_drain_arb
  import fwft_arb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]           ch_rdata_vld,
  output logic [NUM_CH-1:0]           ch_rden,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [$clog2(NUM_CH)-1:0]   out_ch,
  output logic                        out_last,
  input  logic                        stat_clr,
  output logic [NUM_CH*CNT_WIDTH-1:0] stat_cnt
);

  localparam int unsigned IW = $clog2(NUM_CH);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q;
  logic [IW-1:0] ptr_q, gnt_q;
  logic [BW-1:0] burst_q;
  logic          pick_found;
  logic [IW-1:0] pick_idx, pick_start;
  logic          xfer;

  assign pick_start = IW'(next_idx(32'(ptr_q), NUM_CH));

  rr_prio_pick #(
    .N(NUM_CH)
  ) u_pick (
    .req  (ch_rdata_vld),
    .start(pick_start),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Outputs are decoded from state so ch_rden falls with the async reset.
  assign out_vld  = (state_q == ARB_GRANT) && ch_rdata_vld[gnt_q];
  assign out_data = ch_rdata[gnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign out_ch   = gnt_q;
  assign out_last = out_vld && (burst_q == BW'(MAX_BURST - 1));
  assign xfer     = out_vld && out_rdy;

  always_comb begin
    ch_rden = '0;
    if (xfer) ch_rden[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IW'(NUM_CH - 1);
      gnt_q   <= '0;
      burst_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            gnt_q   <= pick_idx;
            ptr_q   <= pick_idx;
            burst_q <= '0;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A bubble on the granted FIFO releases the grant as well.
          if (!ch_rdata_vld[gnt_q] || (xfer && out_last)) begin
            state_q <= ARB_IDLE;
          end else if (xfer) begin
            burst_q <= burst_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef FWFT_RR_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (xfer && (cnt_q[gnt_q] != '1)) begin
      cnt_q[gnt_q] <= cnt_q[gnt_q] + 1'b1;
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fwft_rr_drain_arb.sv
// Scoreboard bench for fwft_rr_drain_arb: FIFO models feed the DUT, expected words are queued.
module tb_fwft_rr_drain_arb;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int BND = 400;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*DW-1:0] ch_rdata;
  logic [NCH-1:0]    ch_rdata_vld;
  logic [NCH-1:0]    ch_rden;
  logic [DW-1:0]     out_data;
  logic              out_vld;
  logic              out_rdy;
  logic [1:0]        out_ch;
  logic              out_last;
  logic              stat_clr;
  logic [NCH*CW-1:0] stat_cnt;

  always #5 clk = ~clk;

  fwft_rr_drain_arb #(
    .NUM_CH    (NCH),
    .DATA_WIDTH(DW),
    .MAX_BURST (16),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_rdata    (ch_rdata),
    .ch_rdata_vld(ch_rdata_vld),
    .ch_rden     (ch_rden),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .stat_clr    (stat_clr),
    .stat_cnt    (stat_cnt)
  );

`ifdef FWFT_RR_ARB_STATS_EN
  logic [NCH-1:0] s_rden;
  logic [DW-1:0]  s_data;
  logic           s_vld, s_last;
  logic [1:0]     s_ch;
  logic [NCH*4-1:0] s_cnt;

  fwft_rr_drain_arb #(
    .NUM_CH    (NCH),
    .DATA_WIDTH(DW),
    .MAX_BURST (16),
    .CNT_WIDTH (4)
  ) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_rdata    (ch_rdata),
    .ch_rdata_vld(ch_rdata_vld),
    .ch_rden     (s_rden),
    .out_data    (s_data),
    .out_vld     (s_vld),
    .out_rdy     (out_rdy),
    .out_ch      (s_ch),
    .out_last    (s_last),
    .stat_clr    (stat_clr),
    .stat_cnt    (s_cnt)
  );
`endif

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t           sbq [$];
  logic [DW-1:0]  fq  [NCH][$];
  logic [NCH-1:0] pend;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic load(input int ch, input logic [DW-1:0] d);
    fq[ch].push_back(d);
  endtask

  task automatic expect_word(input int ch, input logic [DW-1:0] d, input logic last);
    exp_t e;
    e.ch   = 2'(ch);
    e.d    = d;
    e.last = last;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sb(input int left, output int cycles);
    cycles = 0;
    while (sbq.size() > left && cycles < BND) begin
      @(posedge clk);
      cycles++;
    end
    #2;
  endtask

  task automatic fifo_refresh();
    for (int i = 0; i < NCH; i++) begin
      ch_rdata_vld[i]        = (fq[i].size() > 0);
      ch_rdata[i*DW +: DW]   = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  // Pops happen at posedge+1 for strobes seen on the preceding negedge.
  task automatic fifo_loop();
    fifo_refresh();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      end
      fifo_refresh();
      #2;
      fifo_refresh();
    end
  endtask

  task automatic monitor_loop();
    exp_t           e;
    logic [NCH-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = '0;
      end else begin
        pend = ch_rden;
        if (out_vld && out_rdy) begin
          oh         = '0;
          oh[out_ch] = 1'b1;
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL xfer_unexpected: got ch=%0d data=%02h last=%0b, expected none",
                     out_ch, out_data, out_last);
          end else begin
            e = sbq.pop_front();
            if (out_ch !== e.ch || out_data !== e.d || out_last !== e.last || ch_rden !== oh) begin
              n_err++;
              $display("FAIL xfer: got ch=%0d data=%02h last=%0b rden=%b, expected ch=%0d data=%02h last=%0b rden=%b",
                       out_ch, out_data, out_last, ch_rden, e.ch, e.d, e.last, oh);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    out_rdy  = 1'b1;
    stat_clr = 1'b0;
    #12;
    n_cmp++;
    if (ch_rden !== '0 || out_vld !== 1'b0 || out_ch !== 2'd0 || out_last !== 1'b0 ||
        stat_cnt !== '0 || out_data !== ch_rdata[DW-1:0]) begin
      n_err++;
      $display("FAIL reset: got rden=%b vld=%0b ch=%0d last=%0b stat=%h data=%02h, expected zeros",
               ch_rden, out_vld, out_ch, out_last, stat_cnt, out_data);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_rr_order();
    int cyc;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < 16; i++) begin
        load(c, 8'(c * 16 + i));
        expect_word(c, 8'(c * 16 + i), i == 15);
      end
    end
    for (int i = 0; i < 16; i++) begin
      load(0, 8'(8'hE0 + i));
      expect_word(0, 8'(8'hE0 + i), i == 15);
    end
    wait_sb(0, cyc);
    // 5 bursts of 16 words, each preceded by one IDLE cycle.
    n_cmp++;
    if (cyc !== 85) begin
      n_err++;
      $display("FAIL rr_order_cycles: got %0d cycles, expected 85", cyc);
    end
  endtask

  task automatic test_short_burst();
    int cyc;
    for (int i = 0; i < 5; i++) begin
      load(2, 8'(8'h20 + i));
      expect_word(2, 8'(8'h20 + i), 1'b0);
    end
    wait_sb(0, cyc);
    n_cmp++;
    if (cyc >= BND) begin
      n_err++;
      $display("FAIL short_burst_timeout: got %0d cycles, expected < %0d", cyc, BND);
    end
    load(1, 8'hC1);
    expect_word(1, 8'hC1, 1'b0);
    step();
    n_cmp++;
    if (out_vld !== 1'b0) begin
      n_err++;
      $display("FAIL short_burst_idle: got out_vld=%0b, expected 0", out_vld);
    end
    step();
    n_cmp++;
    if (out_vld !== 1'b1 || out_ch !== 2'd1) begin
      n_err++;
      $display("FAIL short_burst_regrant: got vld=%0b ch=%0d, expected vld=1 ch=1", out_vld, out_ch);
    end
    wait_sb(0, cyc);
  endtask

  task automatic test_backpressure();
    int            cyc;
    logic [DW-1:0] d0;
    logic [1:0]    c0;
    logic          l0;
    for (int i = 0; i < 16; i++) begin
      load(3, 8'(8'h30 + i));
      expect_word(3, 8'(8'h30 + i), i == 15);
    end
    wait_sb(11, cyc);
    out_rdy = 1'b0;
    d0 = 8'h35;
    c0 = 2'd3;
    l0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (out_data !== d0 || out_ch !== c0 || out_last !== l0 || out_vld !== 1'b1 ||
          ch_rden !== '0) begin
        n_err++;
        $display("FAIL backpressure_hold: got data=%02h ch=%0d last=%0b vld=%0b rden=%b, expected data=%02h ch=%0d last=%0b vld=1 rden=0",
                 out_data, out_ch, out_last, out_vld, ch_rden, d0, c0, l0);
      end
    end
    n_cmp++;
    if (fq[3].size() !== 11) begin
      n_err++;
      $display("FAIL backpressure_nopop: got %0d words left, expected 11", fq[3].size());
    end
    out_rdy = 1'b1;
    wait_sb(0, cyc);
    n_cmp++;
    if (cyc >= BND) begin
      n_err++;
      $display("FAIL backpressure_timeout: got %0d cycles, expected < %0d", cyc, BND);
    end
  endtask

  task automatic test_fairness();
    int cyc;
    for (int i = 0; i < 32; i++) load(0, 8'(8'h40 + i));
    for (int i = 0; i < 16; i++) expect_word(0, 8'(8'h40 + i), i == 15);
    wait_sb(12, cyc);
    for (int i = 0; i < 4; i++) begin
      load(3, 8'(8'hD0 + i));
      expect_word(3, 8'(8'hD0 + i), 1'b0);
    end
    for (int i = 16; i < 32; i++) expect_word(0, 8'(8'h40 + i), i == 31);
    wait_sb(0, cyc);
    n_cmp++;
    if (cyc >= BND) begin
      n_err++;
      $display("FAIL fairness_timeout: got %0d cycles, expected < %0d", cyc, BND);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    for (int i = 0; i < 16; i++) begin
      load(2, 8'(8'h70 + i));
      expect_word(2, 8'(8'h70 + i), i == 15);
    end
    wait_sb(13, cyc);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ch_rden !== '0 || out_vld !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_rden: got rden=%b vld=%0b, expected rden=0 vld=0", ch_rden, out_vld);
    end
    sbq.delete();
    for (int i = 0; i < 4; i++) load(1, 8'(8'h90 + i));
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (fq[2].size() !== 13 || out_ch !== 2'd0 || ch_rden !== '0) begin
      n_err++;
      $display("FAIL async_reset_hold: got left=%0d ch=%0d rden=%b, expected left=13 ch=0 rden=0",
               fq[2].size(), out_ch, ch_rden);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) expect_word(1, 8'(8'h90 + i), 1'b0);
    for (int i = 3; i < 16; i++) expect_word(2, 8'(8'h70 + i), 1'b0);
    wait_sb(0, cyc);
    n_cmp++;
    if (cyc >= BND) begin
      n_err++;
      $display("FAIL async_reset_timeout: got %0d cycles, expected < %0d", cyc, BND);
    end
  endtask

  task automatic test_stats();
    int cyc;
    step();
`ifdef FWFT_RR_ARB_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    n_cmp++;
    if (stat_cnt !== '0 || s_cnt !== '0) begin
      n_err++;
      $display("FAIL stat_clear: got %h / %h, expected 0", stat_cnt, s_cnt);
    end
`endif
    for (int i = 0; i < 20; i++) begin
      load(1, 8'(8'hA0 + i));
      expect_word(1, 8'(8'hA0 + i), i == 15);
    end
    wait_sb(0, cyc);
    step();
`ifdef FWFT_RR_ARB_STATS_EN
    n_cmp++;
    if (stat_cnt[1*CW +: CW] !== 16'd20) begin
      n_err++;
      $display("FAIL stat_count: got %0d, expected 20", stat_cnt[1*CW +: CW]);
    end
    n_cmp++;
    if (s_cnt[4 +: 4] !== 4'd15) begin
      n_err++;
      $display("FAIL stat_saturate: got %0d, expected 15", s_cnt[4 +: 4]);
    end
    load(1, 8'hEE);
    expect_word(1, 8'hEE, 1'b0);
    cyc = 0;
    while (out_vld !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    n_cmp++;
    if (stat_cnt[1*CW +: CW] !== 16'd0 || s_cnt[4 +: 4] !== 4'd0 || sbq.size() !== 0) begin
      n_err++;
      $display("FAIL stat_clear_wins: got %0d / %0d pending=%0d, expected 0 / 0 pending=0",
               stat_cnt[1*CW +: CW], s_cnt[4 +: 4], sbq.size());
    end
`else
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    n_cmp++;
    if (stat_cnt !== '0) begin
      n_err++;
      $display("FAIL stat_tied: got %h, expected 0", stat_cnt);
    end
`endif
  endtask

  initial begin
    pend = '0;
    fork
      fifo_loop();
      monitor_loop();
    join_none
    test_reset();
    test_rr_order();
    test_short_burst();
    test_backpressure();
    test_fairness();
    test_async_reset();
    test_stats();
    n_cmp++;
    if (sbq.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d words pending, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
